// File: rtl/start_fifo_srl_ctrl.sv
// rtl/start_fifo_srl_ctrl.sv - SRL FIFO controller with FWFT output; START_FIFO_OREG_EN adds a registered output stage
module start_fifo_srl_ctrl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2,
  parameter int AFULL_LVL  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_count
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] srl [DEPTH];
  logic [CW-1:0]         srl_cnt;
  logic [CW-1:0]         srl_cnt_next;
  logic [CW-1:0]         total_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  push;
  logic                  pop;
  logic                  full_n_q;
  logic                  afull_q;

  assign push           = if_write_ce & if_write & full_n_q;
  assign addr           = (srl_cnt == '0) ? '0 : ADDR_WIDTH'(srl_cnt - 1'b1);
  assign if_full_n      = full_n_q;
  assign if_almost_full = afull_q;

  // Shift-in at index 0 keeps the oldest entry at count-1, so addr tracks occupancy
  always_ff @(posedge clk) begin
    if (push) begin
      srl[0] <= if_din;
      for (int i = 1; i < DEPTH; i++) srl[i] <= srl[i-1];
    end
  end

`ifdef START_FIFO_OREG_EN
  logic                  oreg_valid;
  logic                  oreg_valid_next;
  logic                  srl_pop;
  logic [DATA_WIDTH-1:0] oreg_data;

  assign pop             = if_read_ce & if_read & oreg_valid;
  assign srl_pop         = (srl_cnt != '0) & (~oreg_valid | pop);
  assign oreg_valid_next = srl_pop | (oreg_valid & ~pop);
  assign srl_cnt_next    = srl_cnt + CW'(push) - CW'(srl_pop);
  assign total_next      = srl_cnt_next + CW'(oreg_valid_next);
  assign if_dout         = oreg_data;
  assign if_empty_n      = oreg_valid;
  assign if_count        = srl_cnt + CW'(oreg_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oreg_valid <= 1'b0;
      oreg_data  <= '0;
    end else begin
      oreg_valid <= oreg_valid_next;
      if (srl_pop) oreg_data <= srl[addr];
    end
  end
`else
  logic empty_n_q;

  assign pop          = if_read_ce & if_read & empty_n_q;
  assign srl_cnt_next = srl_cnt + CW'(push) - CW'(pop);
  assign total_next   = srl_cnt_next;
  assign if_dout      = srl[addr];
  assign if_empty_n   = empty_n_q;
  assign if_count     = srl_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) empty_n_q <= 1'b0;
    else       empty_n_q <= (srl_cnt_next != '0);
  end
`endif

  // Flags come from the next count so they line up with the updated occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      srl_cnt  <= '0;
      full_n_q <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      srl_cnt  <= srl_cnt_next;
      full_n_q <= (srl_cnt_next != CW'(DEPTH));
      afull_q  <= (total_next >= CW'(AFULL_LVL));
    end
  end

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// tb/tb_start_fifo_srl_ctrl.sv - directed + randomized bench for start_fifo_srl_ctrl against a queue model
module tb_start_fifo_srl_ctrl;

  localparam int DW = 8, AW = 2, DEPTH = 4, AFULL = 3;
`ifdef START_FIFO_OREG_EN
  localparam int CAP = DEPTH + 1;
`else
  localparam int CAP = DEPTH;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_write_ce = 1'b0, if_write = 1'b0, if_read_ce = 1'b0, if_read = 1'b0;
  logic [DW-1:0] if_din = '0;
  logic          if_full_n, if_almost_full, if_empty_n;
  logic [DW-1:0] if_dout;
  logic [AW:0]   if_count;

  int checks = 0;
  int errors = 0;

  start_fifo_srl_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk(clk), .reset(reset),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
    .if_full_n(if_full_n), .if_almost_full(if_almost_full),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
    .if_empty_n(if_empty_n), .if_count(if_count)
  );

  always #5 clk = ~clk;

  // Reference: q holds entries not yet visible; with the output stage, slot_v/slot_d hold the head
  logic [DW-1:0] q[$];
  bit            slot_v = 1'b0;
  logic [DW-1:0] slot_d = '0;
  logic [DW-1:0] last_dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_empty_n();
`ifdef START_FIFO_OREG_EN
    return slot_v;
`else
    return q.size() != 0;
`endif
  endfunction

  function automatic bit m_full_n();
    return q.size() != DEPTH;
  endfunction

  function automatic int m_count();
    return q.size() + int'(slot_v);
  endfunction

  function automatic logic [DW-1:0] m_dout();
`ifdef START_FIFO_OREG_EN
    return slot_d;
`else
    return q[0];
`endif
  endfunction

  task automatic compare();
    chk("empty_n", 32'(if_empty_n), 32'(m_empty_n()));
    chk("full_n", 32'(if_full_n), 32'(m_full_n()));
    chk("almost_full", 32'(if_almost_full), 32'(m_count() >= AFULL));
    chk("count", 32'(if_count), 32'(m_count()));
    if (m_empty_n()) chk("dout", 32'(if_dout), 32'(m_dout()));
    last_dout = if_dout;
  endtask

  task automatic cycle(input bit w, input bit wce, input logic [DW-1:0] d, input bit r, input bit rce);
    bit push, pop, spop;
    @(negedge clk);
    compare();
    push = w && wce && m_full_n();
    pop  = r && rce && m_empty_n();
    if_write = w; if_write_ce = wce; if_din = d; if_read = r; if_read_ce = rce;
    @(posedge clk);
`ifdef START_FIFO_OREG_EN
    spop = (q.size() > 0) && (!slot_v || pop);
    if (spop) begin
      slot_d = q.pop_front();
      slot_v = 1'b1;
    end else if (pop) begin
      slot_v = 1'b0;
    end
`else
    spop = pop;
    if (spop) void'(q.pop_front());
`endif
    if (push) q.push_back(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * CAP + 2 && (m_empty_n() || m_count() != 0); i++)
      cycle(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
  endtask

  initial begin
    logic [DW-1:0] t3_exp [4];
    logic [DW-1:0] t4_exp [5];
    t3_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    t4_exp = '{8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};

    repeat (2) @(negedge clk);
    chk("rst_empty_n", 32'(if_empty_n), 32'd0);
    chk("rst_full_n", 32'(if_full_n), 32'd1);
    chk("rst_afull", 32'(if_almost_full), 32'd0);
    chk("rst_count", 32'(if_count), 32'd0);
    reset = 1'b0;

    // 1: fill with four words
    cycle(1, 1, 8'h11, 0, 1);
    cycle(1, 1, 8'h22, 0, 1);
    cycle(1, 1, 8'h33, 0, 1);
    cycle(1, 1, 8'h44, 0, 1);
    cycle(0, 1, 8'h00, 0, 1);
    chk("t1_count", 32'(if_count), 32'd4);
    chk("t1_full_n", 32'(if_full_n), (CAP == 4) ? 32'd0 : 32'd1);
    chk("t1_afull", 32'(if_almost_full), 32'd1);

    // 2: writes blocked once full
    for (int i = 0; i < 4 && m_full_n(); i++) cycle(1, 1, 8'h45, 0, 1);
    repeat (3) cycle(1, 1, 8'h55, 0, 1);
    idle(1);
    chk("t2_count", 32'(if_count), 32'(CAP));

    // 3: pop in order
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 8'h00, 1, 1);
      chk("t3_order", 32'(last_dout), 32'(t3_exp[i]));
    end
    drain();
    idle(1);
    chk("t3_empty_count", 32'(if_count), 32'd0);

    // 4: simultaneous push/pop at count 2
    cycle(1, 1, 8'hA1, 0, 1);
    cycle(1, 1, 8'hA2, 0, 1);
    idle(1);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 8'hB0 + 8'(i), 1, 1);
      chk("t4_order", 32'(last_dout), 32'(t4_exp[i]));
      chk("t4_count", 32'(if_count), 32'd2);
    end
    drain();

    // 5: read ce gating, empty then with data
    for (int i = 0; i < 6; i++) cycle(0, 1, 8'h00, 1, 1'(i % 2));
    cycle(1, 1, 8'hC1, 0, 1);
    cycle(1, 1, 8'hC2, 0, 1);
    idle(1);
    for (int i = 0; i < 6; i++) cycle(0, 1, 8'h00, 1, 1'(i % 2));
    drain();

    // 6: asynchronous reset mid-stream at count 3
    cycle(1, 1, 8'hD1, 0, 1);
    cycle(1, 1, 8'hD2, 0, 1);
    cycle(1, 1, 8'hD3, 0, 1);
    idle(1);
    @(negedge clk);
    chk("t6_pre_count", 32'(if_count), 32'd3);
    if_write = 1'b1; if_din = 8'hEE;
    #2 reset = 1'b1;
    #1;
    chk("t6_empty_n", 32'(if_empty_n), 32'd0);
    chk("t6_full_n", 32'(if_full_n), 32'd1);
    chk("t6_count", 32'(if_count), 32'd0);
    if_write = 1'b0;
    q.delete(); slot_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle(1, 1, 8'h77, 0, 1);
    idle(2);
    @(negedge clk);
    chk("t6_dout", 32'(if_dout), 32'h77);

    // randomized interleaving
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 9) != 0), 8'($urandom),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 9) != 0));
    drain();
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
